loop_nest_ctrl: RTL and testbench
=================================

Name: loop_nest_ctrl

Overview:
- Three-level nested loop sequencer for the accelerator datapath (inner = level 0, outer = level 2).
- Each level is an inclusive-max wrap counter, with the same counting rule as the team's counter status register.
- Produces one index tuple per beat under a valid/ready handshake, signals run completion, and exposes status and progress on the PS read bus.

Parameters:
- DATA_WIDTH, 32, PS read data width and beat-counter width.
- ADDR_WIDTH, 32, PS address width.
- CNT_WIDTH, 16, width of each loop index/max; must be <= DATA_WIDTH.
- REG_ADDR_BASE, 32'h00000010, address of first status register; registers occupy REG_ADDR_BASE+0 .. +4.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- istart  input  1  start pulse; accepted only in IDLE
- imax0  input  CNT_WIDTH  inner loop max (inclusive), sampled on accepted istart
- imax1  input  CNT_WIDTH  middle loop max (inclusive), sampled on accepted istart
- imax2  input  CNT_WIDTH  outer loop max (inclusive), sampled on accepted istart
- ovalid  output  1  index tuple valid
- iready  input  1  downstream accepts tuple
- oidx0  output  CNT_WIDTH  inner index
- oidx1  output  CNT_WIDTH  middle index
- oidx2  output  CNT_WIDTH  outer index
- olast  output  1  high with the final tuple of the run
- obusy  output  1  high in RUN
- odone  output  1  one-cycle pulse after final beat accepted
- ps_addr  input  ADDR_WIDTH  PS read address
- ps_rden  input  1  PS read enable
- ps_rdat  output  DATA_WIDTH  PS read data
- ps_rvld  output  1  PS read data valid

Behaviour:
- Clock and reset: clk; rst synchronous, active-high.
- Reset values: all outputs 0; state IDLE; latched maxes 0; beat and run counters 0; done_sticky 0. rst in any state, including mid-run, aborts immediately. No odone is produced for an aborted run.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: on istart. Latch imax0..2, clear idx0..2, clear done_sticky.
  - RUN -> DONE: on accepted beat (ovalid & iready) with olast=1.
  - DONE -> IDLE: unconditionally, next cycle.
- istart in RUN or DONE is ignored: no relatch, no restart.
- Beat handshake in RUN:
  - ovalid=1 every RUN cycle.
  - oidx0..2 are registered and hold stable while ovalid & !iready.
  - ovalid and oidx* are first valid the cycle after istart (1-cycle start latency).
- Index advance, on accepted beat only:
  - idx0 = max0 ? 0 : idx0+1.
  - idx1 advances only when idx0 wraps: idx1 = max1 ? 0 : idx1+1.
  - idx2 advances only when idx0 and idx1 both wrap.
  - Equality compares use full CNT_WIDTH; no overflow past max.
- olast = ovalid & (idx0==max0) & (idx1==max1) & (idx2==max2).
- Beats per run = (max0+1)*(max1+1)*(max2+1). All-zero maxes give exactly one beat with olast=1.
- Throughput: one beat per cycle with iready held high; no bubble between beats. Back-to-back runs incur IDLE/DONE gap of 2 cycles minimum.
- DONE: odone=1 for exactly one cycle, obusy=0, ovalid=0. Set done_sticky and increment run counter.
- Beat counter: DATA_WIDTH bits; increments on every accepted beat; wraps at 2^DATA_WIDTH; not cleared by istart.
- Run counter: DATA_WIDTH bits; increments on every DONE; wraps; not cleared by istart.
- PS read registers: hit = ps_rden & address equals one of the five registers below. Registered: ps_rvld and ps_rdat appear 1 cycle after ps_rden. ps_rdat=0 when ps_rvld=0. Non-hit reads give ps_rvld=0.
  - +0: {zero-fill, done_sticky[1], busy[0]}.
  - +1: zero-extended idx0.
  - +2: zero-extended idx1.
  - +3: zero-extended idx2.
  - +4: beat counter.
  - Reads have no side effects. Reads concurrent with index update return the pre-update value (value registered on the ps_rden cycle).

Test Plan:
- imax0=1, imax1=2, imax2=0, istart, iready=1 -> 6 beats (idx0,idx1) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2); olast only on 6th; odone 1 cycle after; beat counter=6.
- Same config, iready toggled 1,0,0,1,... -> indices held stable while stalled; same 6-tuple sequence; odone only after 6th acceptance.
- All maxes 0 -> single beat with olast=1; ovalid for exactly one accepted cycle; run counter increments by 1.
- istart re-pulsed mid-run with different maxes -> ignored; run completes with original maxes; then new istart accepted from IDLE.
- rst asserted after 3rd beat of 2x2x2 run -> next cycle all outputs 0, state IDLE, no odone; subsequent istart runs 8 beats from (0,0,0).
- PS reads: read REG_ADDR_BASE+0 during run -> ps_rvld 1 cycle later, rdat=1. After done -> rdat=2. Read +4 -> beat count. Read REG_ADDR_BASE+5 -> ps_rvld=0, ps_rdat=0.

Source files
------------

// File: rtl/loop_nest_ctrl.sv
// loop_nest_ctrl
//   Three-level nested loop sequencer. Level 0 is the inner loop and level 2
//   is the outer loop. Each level counts 0..max inclusive and then wraps.
//   One index tuple is produced per beat. A status/progress register bank
//   is readable over the PS bus.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   istart              start pulse, accepted only in IDLE
//   imax0..imax2        inclusive loop maxima, sampled on accepted istart
//   ovalid / iready     beat handshake (see below)
//   oidx0..oidx2        registered loop indices (inner .. outer)
//   olast               high with the final tuple of the run
//   obusy               high while in RUN
//   odone               one-cycle pulse after the final beat is accepted
//   ps_addr, ps_rden    PS read request
//   ps_rdat, ps_rvld    PS read response, registered (1-cycle latency)
//   dbg_state_o         current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a beat transfers on a rising clk edge where ovalid & iready.
// While ovalid & !iready the tuple (oidx*, olast) holds stable. ovalid never
// drops in RUN until the last beat has been accepted.
//
// PS register map (word offsets from REG_ADDR_BASE)
//   +0 {zero, done_sticky, busy}   +1 idx0   +2 idx1   +3 idx2   +4 beat count
module loop_nest_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] REG_ADDR_BASE = 32'h0000_0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  istart,
    input  logic [CNT_WIDTH-1:0]  imax0,
    input  logic [CNT_WIDTH-1:0]  imax1,
    input  logic [CNT_WIDTH-1:0]  imax2,
    output logic                  ovalid,
    input  logic                  iready,
    output logic [CNT_WIDTH-1:0]  oidx0,
    output logic [CNT_WIDTH-1:0]  oidx1,
    output logic [CNT_WIDTH-1:0]  oidx2,
    output logic                  olast,
    output logic                  obusy,
    output logic                  odone,
    input  logic [ADDR_WIDTH-1:0] ps_addr,
    input  logic                  ps_rden,
    output logic [DATA_WIDTH-1:0] ps_rdat,
    output logic                  ps_rvld,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  max0_q, max0_d, max1_q, max1_d, max2_q, max2_d;
    logic [CNT_WIDTH-1:0]  idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d;
    logic                  done_sticky_q, done_sticky_d;
    logic [DATA_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic                  rvld_q, rvld_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;

    logic wrap0, wrap1, wrap2, beat_acc, in_run;

    assign in_run   = (state_q == S_RUN);
    assign wrap0    = (idx0_q == max0_q);
    assign wrap1    = (idx1_q == max1_q);
    assign wrap2    = (idx2_q == max2_q);
    assign beat_acc = in_run & iready;

    assign ovalid      = in_run;
    assign obusy       = in_run;
    assign odone       = (state_q == S_DONE);
    assign olast       = in_run & wrap0 & wrap1 & wrap2;
    assign oidx0       = idx0_q;
    assign oidx1       = idx1_q;
    assign oidx2       = idx2_q;
    assign ps_rvld     = rvld_q;
    assign ps_rdat     = rdat_q;
    assign dbg_state_o = state_q;

    // Sequencer FSM and counters
    always_comb begin
        state_d       = state_q;
        max0_d        = max0_q;
        max1_d        = max1_q;
        max2_d        = max2_q;
        idx0_d        = idx0_q;
        idx1_d        = idx1_q;
        idx2_d        = idx2_q;
        done_sticky_d = done_sticky_q;
        beat_cnt_d    = beat_cnt_q;
        run_cnt_d     = run_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    state_d       = S_RUN;
                    max0_d        = imax0;
                    max1_d        = imax1;
                    max2_d        = imax2;
                    idx0_d        = '0;
                    idx1_d        = '0;
                    idx2_d        = '0;
                    done_sticky_d = 1'b0;
                end
            end
            S_RUN: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // Carry ripples outward only on wrap of every inner level.
                    idx0_d = wrap0 ? '0 : idx0_q + 1'b1;
                    if (wrap0) begin
                        idx1_d = wrap1 ? '0 : idx1_q + 1'b1;
                        if (wrap1) begin
                            idx2_d = wrap2 ? '0 : idx2_q + 1'b1;
                        end
                    end
                    if (wrap0 && wrap1 && wrap2) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                done_sticky_d = 1'b1;
                run_cnt_d     = run_cnt_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // PS read decode; the value is captured on the ps_rden cycle so a read
    // coinciding with an index update returns the pre-update value.
    always_comb begin
        rvld_d = 1'b0;
        rdat_d = '0;
        if (ps_rden) begin
            if (ps_addr == REG_ADDR_BASE) begin
                rvld_d = 1'b1;
                rdat_d = {{(DATA_WIDTH-2){1'b0}}, done_sticky_q, in_run};
            end else if (ps_addr == REG_ADDR_BASE + ADDR_WIDTH'(1)) begin
                rvld_d = 1'b1;
                rdat_d = DATA_WIDTH'(idx0_q);
            end else if (ps_addr == REG_ADDR_BASE + ADDR_WIDTH'(2)) begin
                rvld_d = 1'b1;
                rdat_d = DATA_WIDTH'(idx1_q);
            end else if (ps_addr == REG_ADDR_BASE + ADDR_WIDTH'(3)) begin
                rvld_d = 1'b1;
                rdat_d = DATA_WIDTH'(idx2_q);
            end else if (ps_addr == REG_ADDR_BASE + ADDR_WIDTH'(4)) begin
                rvld_d = 1'b1;
                rdat_d = beat_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            max0_q        <= '0;
            max1_q        <= '0;
            max2_q        <= '0;
            idx0_q        <= '0;
            idx1_q        <= '0;
            idx2_q        <= '0;
            done_sticky_q <= 1'b0;
            beat_cnt_q    <= '0;
            run_cnt_q     <= '0;
            rvld_q        <= 1'b0;
            rdat_q        <= '0;
        end else begin
            state_q       <= state_d;
            max0_q        <= max0_d;
            max1_q        <= max1_d;
            max2_q        <= max2_d;
            idx0_q        <= idx0_d;
            idx1_q        <= idx1_d;
            idx2_q        <= idx2_d;
            done_sticky_q <= done_sticky_d;
            beat_cnt_q    <= beat_cnt_d;
            run_cnt_q     <= run_cnt_d;
            rvld_q        <= rvld_d;
            rdat_q        <= rdat_d;
        end
    end

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Directed bench for loop_nest_ctrl. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled at that same point.
module tb_loop_nest_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam logic [AW-1:0] BASE = 32'h0000_0010;

    logic          clk = 1'b0;
    logic          rst;
    logic          istart;
    logic [CW-1:0] imax0, imax1, imax2;
    logic          ovalid, iready;
    logic [CW-1:0] oidx0, oidx1, oidx2;
    logic          olast, obusy, odone;
    logic [AW-1:0] ps_addr;
    logic          ps_rden;
    logic [DW-1:0] ps_rdat;
    logic          ps_rvld;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // expected tuples, packed {idx2, idx1, idx0}
    logic [3*CW-1:0] exp_q[$];

    loop_nest_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .REG_ADDR_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .istart(istart),
        .imax0(imax0), .imax1(imax1), .imax2(imax2),
        .ovalid(ovalid), .iready(iready),
        .oidx0(oidx0), .oidx1(oidx1), .oidx2(oidx2),
        .olast(olast), .obusy(obusy), .odone(odone),
        .ps_addr(ps_addr), .ps_rden(ps_rden), .ps_rdat(ps_rdat), .ps_rvld(ps_rvld),
        .dbg_state_o(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ps_read(input logic [AW-1:0] addr, input logic exp_vld, input logic [DW-1:0] exp_dat,
                           input string tag);
        ps_addr = addr;
        ps_rden = 1'b1;
        step();
        ps_rden = 1'b0;
        check_eq({tag, "_rvld"}, 64'(ps_rvld), 64'(exp_vld));
        check_eq({tag, "_rdat"}, 64'(ps_rdat), 64'(exp_dat));
    endtask

    // Runs one full sequence from IDLE. stall uses iready pattern 1,0,0,...
    // restart pulses istart with other maxima partway through the run.
    task automatic do_run(input logic [CW-1:0] m0, input logic [CW-1:0] m1, input logic [CW-1:0] m2,
                          input bit stall, input bit restart, input string tag);
        int cyc;
        exp_q.delete();
        for (int k2 = 0; k2 <= int'(m2); k2++)
            for (int k1 = 0; k1 <= int'(m1); k1++)
                for (int k0 = 0; k0 <= int'(m0); k0++)
                    exp_q.push_back({CW'(k2), CW'(k1), CW'(k0)});
        istart = 1'b1;
        imax0 = m0; imax1 = m1; imax2 = m2;
        step();
        istart = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            iready = stall ? (cyc % 3 == 0) : 1'b1;
            if (restart && cyc == 2) begin
                istart = 1'b1;
                imax0 = 16'd7; imax1 = 16'd7; imax2 = 16'd7;
            end else begin
                istart = 1'b0;
            end
            check_eq({tag, "_ovalid"}, 64'(ovalid), 64'd1);
            check_eq({tag, "_idx"}, 64'({oidx2, oidx1, oidx0}), 64'(exp_q[0]));
            check_eq({tag, "_olast"}, 64'(olast), 64'(exp_q.size() == 1));
            if (iready) void'(exp_q.pop_front());
            step();
            cyc++;
        end
        istart = 1'b0;
        iready = 1'b0;
        check_eq({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_odone"}, 64'(odone), 64'd1);
        check_eq({tag, "_done_ovalid"}, 64'(ovalid), 64'd0);
        check_eq({tag, "_done_obusy"}, 64'(obusy), 64'd0);
        step();
        check_eq({tag, "_odone_clr"}, 64'(odone), 64'd0);
        check_eq({tag, "_idle"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        rst = 1'b1; istart = 1'b0; iready = 1'b0;
        imax0 = '0; imax1 = '0; imax2 = '0;
        ps_addr = '0; ps_rden = 1'b0;
        repeat (3) step();

        // reset state
        check_eq("rst_ovalid", 64'(ovalid), 64'd0);
        check_eq("rst_obusy", 64'(obusy), 64'd0);
        check_eq("rst_odone", 64'(odone), 64'd0);
        check_eq("rst_olast", 64'(olast), 64'd0);
        check_eq("rst_idx", 64'({oidx2, oidx1, oidx0}), 64'd0);
        check_eq("rst_rvld", 64'(ps_rvld), 64'd0);
        check_eq("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        step();

        // 2x3x1 run, iready held high: 6 beats
        do_run(16'd1, 16'd2, 16'd0, 1'b0, 1'b0, "t1");
        ps_read(BASE + 4, 1'b1, 32'd6, "t1_beats");

        // same config with stalls
        do_run(16'd1, 16'd2, 16'd0, 1'b1, 1'b0, "t2");
        ps_read(BASE + 4, 1'b1, 32'd12, "t2_beats");

        // all-zero maxes: one beat with olast
        do_run(16'd0, 16'd0, 16'd0, 1'b0, 1'b0, "t3");
        check_eq("t3_run_cnt", 64'(dut.run_cnt_q), 64'd3);
        ps_read(BASE + 4, 1'b1, 32'd13, "t3_beats");

        // istart mid-run is ignored; a later istart from IDLE is honoured
        do_run(16'd1, 16'd2, 16'd0, 1'b0, 1'b1, "t4a");
        do_run(16'd2, 16'd0, 16'd1, 1'b0, 1'b0, "t4b");
        ps_read(BASE + 4, 1'b1, 32'd25, "t4_beats");

        // reset after the third accepted beat of a 2x2x2 run
        istart = 1'b1; imax0 = 16'd1; imax1 = 16'd1; imax2 = 16'd1; iready = 1'b1;
        step();
        istart = 1'b0;
        check_eq("t5_idx_b0", 64'({oidx2, oidx1, oidx0}), 64'h0000_0000_0000);
        step();
        check_eq("t5_idx_b1", 64'({oidx2, oidx1, oidx0}), 64'h0000_0000_0001);
        step();
        check_eq("t5_idx_b2", 64'({oidx2, oidx1, oidx0}), 64'h0000_0001_0000);
        step();
        rst = 1'b1;
        iready = 1'b0;
        step();
        check_eq("t5_ovalid", 64'(ovalid), 64'd0);
        check_eq("t5_obusy", 64'(obusy), 64'd0);
        check_eq("t5_odone", 64'(odone), 64'd0);
        check_eq("t5_idx", 64'({oidx2, oidx1, oidx0}), 64'd0);
        check_eq("t5_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        step();
        check_eq("t5_no_odone", 64'(odone), 64'd0);
        ps_read(BASE + 4, 1'b1, 32'd0, "t5_beats_rst");
        do_run(16'd1, 16'd1, 16'd1, 1'b0, 1'b0, "t5run");
        ps_read(BASE + 4, 1'b1, 32'd8, "t5_beats");

        // PS reads during and after a run
        istart = 1'b1; imax0 = 16'd1; imax1 = 16'd2; imax2 = 16'd0; iready = 1'b0;
        step();
        istart = 1'b0;
        ps_read(BASE + 0, 1'b1, 32'd1, "t6_stat_run");
        iready = 1'b1;
        ps_read(BASE + 1, 1'b1, 32'd0, "t6_idx0_pre");
        iready = 1'b0;
        ps_read(BASE + 1, 1'b1, 32'd1, "t6_idx0_post");
        ps_read(BASE + 3, 1'b1, 32'd0, "t6_idx2");
        iready = 1'b1;
        for (int i = 0; i < 20 && !odone; i++) step();
        iready = 1'b0;
        check_eq("t6_odone", 64'(odone), 64'd1);
        step();
        ps_read(BASE + 0, 1'b1, 32'd2, "t6_stat_done");
        ps_read(BASE + 4, 1'b1, 32'd14, "t6_beats");
        ps_read(BASE + 5, 1'b0, 32'd0, "t6_miss");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
